sevenseg_bank_scan: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 21 ++
 rtl/hex7seg_decode.sv | 11 +
 rtl/sevenseg_bank_scan.sv | 193 +++++++++++++++++++
 tb/tb_sevenseg_bank_scan.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and glyph table for the multi-bank seven-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high until polarised.
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // 0-9, then A b C d E F
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts active-high segment bits to pin levels for the board's polarity.
    function automatic logic [6:0] seg_drive(input logic [6:0] lit, input bit active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to {g,f,e,d,c,b,a} decoder (active-high segments).
module hex7seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = GLYPH[nibble];

endmodule

// File: rtl/sevenseg_bank_scan.sv
// Multi-bank 7-segment scanner with anti-ghost blanking and frame-synchronous double buffering.
// Define SEVENSEG_DIM_EN to add the brightness port and 16-slot PWM anode dimming.
module sevenseg_bank_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_BANKS       = 2,
    parameter int DIGITS_PER_BANK = 4,
    parameter int ON_CYCLES       = 100000,
    parameter int BLANK_CYCLES    = 1000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   load,
    input  logic [NUM_BANKS*DIGITS_PER_BANK*4-1:0] digit_data,
    input  logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   dp_in,
    input  logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   digit_en,
`ifdef SEVENSEG_DIM_EN
    input  logic [3:0]                             brightness,
`endif
    output logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   an,
    output logic [NUM_BANKS*7-1:0]                 seg,
    output logic [NUM_BANKS-1:0]                   dp,
    output logic                                   frame_done
);

    localparam int NUM_DIGITS = NUM_BANKS * DIGITS_PER_BANK;
    localparam int CNT_MAX    = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(CNT_MAX);
    localparam int IW         = (DIGITS_PER_BANK > 1) ? $clog2(DIGITS_PER_BANK) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS_PER_BANK - 1);

    scan_state_t             state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [NUM_DIGITS*4-1:0] pend_data_reg, act_data_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
    logic [NUM_DIGITS-1:0]   pend_en_reg, act_en_reg;
    logic                    pend_flag_reg;
    logic                    wrap_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [NUM_BANKS*7-1:0]  seg_reg;
    logic [NUM_BANKS-1:0]    dp_reg;
    logic                    frame_done_reg;

    logic                    cnt_last;
    logic                    frame_wrap;
    logic                    is_on;
    logic                    anode_gate;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [NUM_BANKS*7-1:0]  seg_next;
    logic [NUM_BANKS-1:0]    dp_next;

    assign is_on      = (state_reg == ON);
    assign cnt_last   = is_on ? (cnt_reg == ON_LAST) : (cnt_reg == BLANK_LAST);
    assign frame_wrap = is_on && cnt_last && (idx_reg == IDX_LAST);

`ifdef SEVENSEG_DIM_EN
    localparam int SLOT_CYCLES = ON_CYCLES / 16;
    localparam int SW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

    logic [SW-1:0] slot_cnt_reg;
    logic [3:0]    slot_idx_reg;
    logic [3:0]    bright_reg;

    // Brightness is latched on the BLANK->ON edge so a level change never splits an ON phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_reg <= '0;
            slot_idx_reg <= '0;
            bright_reg   <= '0;
        end else if (!is_on) begin
            slot_cnt_reg <= '0;
            slot_idx_reg <= '0;
            if (cnt_last) begin
                bright_reg <= brightness;
            end
        end else if (slot_cnt_reg == SLOT_LAST) begin
            slot_cnt_reg <= '0;
            slot_idx_reg <= slot_idx_reg + 4'd1;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + SW'(1);
        end
    end

    assign anode_gate = (slot_idx_reg <= bright_reg);
`else
    assign anode_gate = 1'b1;
`endif

    genvar gi, gd;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam int BASE = gi * DIGITS_PER_BANK;
            logic [3:0] nib_sel;
            logic       en_sel;
            logic       dp_sel;
            logic       lit;
            logic [6:0] glyph;

            always_comb begin
                nib_sel = '0;
                en_sel  = 1'b0;
                dp_sel  = 1'b0;
                for (int d = 0; d < DIGITS_PER_BANK; d++) begin
                    if (idx_reg == IW'(d)) begin
                        nib_sel = act_data_reg[(BASE + d)*4 +: 4];
                        en_sel  = act_en_reg[BASE + d];
                        dp_sel  = act_dp_reg[BASE + d];
                    end
                end
            end

            hex7seg_decode u_decode (
                .nibble   (nib_sel),
                .segments (glyph)
            );

            // seg/dp stay up for the whole ON phase; only the anode is PWM-gated.
            assign lit                = is_on && en_sel;
            assign seg_next[gi*7 +: 7] = seg_drive(lit ? glyph : 7'h00, ACTIVE_LOW);
            assign dp_next[gi]         = ACTIVE_LOW ^ (lit && dp_sel);

            for (gd = 0; gd < DIGITS_PER_BANK; gd++) begin : g_anode
                assign an_next[BASE + gd] = ACTIVE_LOW ^ (is_on && (idx_reg == IW'(gd))
                                                         && act_en_reg[BASE + gd] && anode_gate);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= BLANK;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            pend_data_reg  <= '0;
            pend_dp_reg    <= '0;
            pend_en_reg    <= '0;
            pend_flag_reg  <= 1'b0;
            act_data_reg   <= '0;
            act_dp_reg     <= '0;
            act_en_reg     <= '0;
            wrap_reg       <= 1'b0;
            an_reg         <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_reg        <= {NUM_BANKS{seg_drive(7'h00, ACTIVE_LOW)}};
            dp_reg         <= {NUM_BANKS{ACTIVE_LOW}};
            frame_done_reg <= 1'b0;
        end else begin
            if (cnt_last) begin
                cnt_reg <= '0;
                if (!is_on) begin
                    state_reg <= ON;
                end else begin
                    state_reg <= BLANK;
                    idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
                end
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            // A load coinciding with the wrap lands in pending and keeps the flag set;
            // the older pending contents are the ones promoted.
            if (frame_wrap && pend_flag_reg) begin
                act_data_reg <= pend_data_reg;
                act_dp_reg   <= pend_dp_reg;
                act_en_reg   <= pend_en_reg;
            end
            if (load) begin
                pend_data_reg <= digit_data;
                pend_dp_reg   <= dp_in;
                pend_en_reg   <= digit_en;
                pend_flag_reg <= 1'b1;
            end else if (frame_wrap) begin
                pend_flag_reg <= 1'b0;
            end

            wrap_reg       <= frame_wrap;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_done_reg <= wrap_reg;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sevenseg_bank_scan.sv
// Randomized scoreboard bench for sevenseg_bank_scan: expected output waveform is derived per cycle
// from frame arithmetic and a "latest load before the frame boundary" rule, then compared as runs.
module tb_sevenseg_bank_scan;

    localparam int NB    = 2;
    localparam int DPB   = 4;
    localparam int ND    = NB * DPB;
    localparam int ONC   = 16;
    localparam int BLC   = 2;
    localparam int PER   = BLC + ONC;
    localparam int FRAME = DPB * PER;
    localparam int VW    = 1 + ND + NB*7 + NB;
    localparam logic [VW-1:0] IDLE = {1'b0, {(VW-1){1'b1}}};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [ND*4-1:0] digit_data = '0;
    logic [ND-1:0]   dp_in = '0;
    logic [ND-1:0]   digit_en = '0;
`ifdef SEVENSEG_DIM_EN
    logic [3:0]      brightness = 4'd15;
`endif
    logic [ND-1:0]   an;
    logic [NB*7-1:0] seg;
    logic [NB-1:0]   dp;
    logic            frame_done;

    sevenseg_bank_scan #(
        .NUM_BANKS       (NB),
        .DIGITS_PER_BANK (DPB),
        .ON_CYCLES       (ONC),
        .BLANK_CYCLES    (BLC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
`ifdef SEVENSEG_DIM_EN
        .brightness (brightness),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              t;
        logic [ND*4-1:0] data;
        logic [ND-1:0]   dpv;
        logic [ND-1:0]   en;
    } load_t;

    typedef struct {
        logic [VW-1:0] val;
        int            len;
    } run_t;

    load_t       plan[$];
    run_t        exp_q[$];
    logic [6:0]  glyph_tab [16];
    int          checks = 0;
    int          passes = 0;

    // Expected {frame_done, an, seg, dp} after clock edge t (edge 0 = first edge out of reset).
    function automatic logic [VW-1:0] exp_at(input int t);
        int              frame, pos, digit, on_cyc, best, k;
        logic [ND-1:0]   an_e;
        logic [NB*7-1:0] seg_e;
        logic [NB-1:0]   dp_e;
        logic [3:0]      nib;
        logic            fd;
        frame  = t / FRAME;
        pos    = t % FRAME;
        digit  = pos / PER;
        on_cyc = (pos % PER) - BLC;
        an_e   = '1;
        seg_e  = '1;
        dp_e   = '1;
        fd     = (pos == 0) && (frame > 0);
        best   = -1;
        if (frame > 0) begin
            for (int i = 0; i < plan.size(); i++) begin
                if (plan[i].t < frame*FRAME - 1) best = i;
            end
        end
        if (on_cyc >= 0 && best >= 0) begin
            for (int b = 0; b < NB; b++) begin
                k = b*DPB + digit;
                if (plan[best].en[k]) begin
                    nib = 4'(plan[best].data >> (4*k));
                    seg_e[b*7 +: 7] = ~glyph_tab[nib];
                    dp_e[b] = ~plan[best].dpv[k];
`ifdef SEVENSEG_DIM_EN
                    if (on_cyc / (ONC/16) <= int'(brightness)) an_e[k] = 1'b0;
`else
                    an_e[k] = 1'b0;
`endif
                end
            end
        end
        return {fd, an_e, seg_e, dp_e};
    endfunction

    function automatic void add_load(input int t, input logic [ND*4-1:0] data,
                                     input logic [ND-1:0] dpv, input logic [ND-1:0] en);
        load_t l;
        l.t = t; l.data = data; l.dpv = dpv; l.en = en;
        plan.push_back(l);
    endfunction

    // ---------------- monitor ----------------
    logic          rst_q = 1'b0;
    int            mon_req = 0;
    int            mon_ack = 0;
    int            mon_n = 0;
    int            mon_cnt = 0;
    int            run_no = 0;
    bit            mon_busy = 1'b0;
    logic [VW-1:0] cur_val = '0;
    int            cur_len = 0;

    always @(posedge clk) rst_q <= reset;

    task automatic close_run();
        run_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL run_%0d: got %h x%0d, expected no further run", run_no, cur_val, cur_len);
        end else begin
            e = exp_q.pop_front();
            if (e.val === cur_val && e.len == cur_len) begin
                passes++;
                $display("run_%0d: %h x%0d ok", run_no, cur_val, cur_len);
            end else begin
                $display("FAIL run_%0d: got %h x%0d, want %h x%0d", run_no, cur_val, cur_len, e.val, e.len);
            end
        end
        run_no++;
    endtask

    always @(negedge clk) begin
        logic [VW-1:0] v;
        v = {frame_done, an, seg, dp};
        if (rst_q) begin
            checks++;
            if (v === IDLE) begin
                passes++;
                $display("reset_idle: %h ok", v);
            end else begin
                $display("FAIL reset_idle: got %h want %h", v, IDLE);
            end
        end else begin
            if (!mon_busy && mon_req != mon_ack) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
            if (mon_busy) begin
                if (mon_cnt == 0) begin
                    cur_val = v;
                    cur_len = 1;
                end else if (v === cur_val) begin
                    cur_len++;
                end else begin
                    close_run();
                    cur_val = v;
                    cur_len = 1;
                end
                mon_cnt++;
                if (mon_cnt == mon_n) begin
                    close_run();
                    checks++;
                    if (exp_q.size() == 0) passes++;
                    else $display("FAIL session_end: %0d expected runs unseen, want 0", exp_q.size());
                    exp_q.delete();
                    mon_busy = 1'b0;
                    mon_ack  = mon_req;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_session(input int n);
        run_t          r;
        logic [VW-1:0] v;
        int            pi;
`ifdef SEVENSEG_DIM_EN
        brightness = 4'($urandom_range(0, 15));
`endif
        exp_q.delete();
        r.val = '0;
        r.len = 0;
        for (int t = 0; t < n; t++) begin
            v = exp_at(t);
            if (t == 0 || v !== r.val) begin
                if (t > 0) exp_q.push_back(r);
                r.val = v;
                r.len = 1;
            end else begin
                r.len++;
            end
        end
        exp_q.push_back(r);

        pi = 0;
        reset = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (pi < plan.size() && plan[pi].t == c) begin
                load       = 1'b1;
                digit_data = plan[pi].data;
                dp_in      = plan[pi].dpv;
                digit_en   = plan[pi].en;
                pi++;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                mon_n = n;
                mon_req++;
            end
        end
        load  = 1'b0;
        reset = 1'b1;
        for (int w = 0; w < 50 && mon_ack != mon_req; w++) @(negedge clk);
        if (mon_ack != mon_req) begin
            $display("FAIL monitor_timeout: session of %0d cycles not closed, want closed", n);
            $display("%0d/%0d checks passed", passes, checks + 1);
            $fatal(1, "monitor stalled");
        end
        repeat (3) @(posedge clk);
        #1;
        plan.delete();
    endtask

    initial begin
        int t;
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Idle scan, first load, then an all-F load while digit 1 is lit.
        add_load(150, 32'h76543210, 8'h00, 8'hFF);
        add_load(4*FRAME + 25, 32'hFFFFFFFF, 8'h5A, 8'hFF);
        run_session(6*FRAME + 10);

        // Load A just before the wrap edge and B on the wrap edge.
        add_load(2*FRAME - 2, $urandom(), 8'($urandom()), 8'hFF);
        add_load(2*FRAME - 1, $urandom(), 8'($urandom()), 8'hFF);
        run_session(4*FRAME + 5);

        // Bank 1 disabled entirely.
        add_load(5, $urandom(), 8'($urandom()), 8'h0F);
        run_session(5*FRAME);

        // Reset lands during digit 2's ON phase, then a load-free session shows cleared buffers.
        add_load(3, $urandom(), 8'($urandom()), 8'hFF);
        add_load(100, $urandom(), 8'($urandom()), 8'($urandom()));
        run_session(2*FRAME + 46);
        run_session(2*FRAME + 4);

        // Random load schedules.
        for (int s = 0; s < 3; s++) begin
            t = $urandom_range(0, 40);
            while (t < 7*FRAME) begin
                add_load(t, $urandom(), 8'($urandom()), 8'($urandom()));
                t += $urandom_range(10, 160);
            end
            run_session(8*FRAME);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
